bus_dma_master: RTL
===================

Name: bus_dma_master

Overview:
Bus initiator for the memory-mapped peripheral bus (rd, wr, addr, wdata, rdata, r_accessible, w_accessible). It copies N 32-bit words from a source address to a destination address, one word at a time, using read-then-write transactions. It sits beside the CPU, and the top level muxes the bus using a req/gnt pair. Typical use is moving blocks between data memory and peripherals, for example polling the switch register into led/digi.

Parameters:
ADDR_W, 32, bus address width.
CNT_W, 16, width of the word-count register.

Ports:
clk  in  1  system clock, all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse that launches a transfer; ignored while busy.
cfg_src  in  ADDR_W  source byte address, captured on accepted start.
cfg_dst  in  ADDR_W  destination byte address, captured on accepted start.
cfg_cnt  in  CNT_W  number of words, captured on accepted start.
cfg_src_inc  in  1  1: source address advances by 4 per word; 0: source address is fixed.
cfg_dst_inc  in  1  1: destination address advances by 4 per word; 0: destination address is fixed.
busy  out  1  high from the cycle after an accepted start until DONE or ERR is reached.
done  out  1  one-cycle pulse on normal completion.
err  out  1  sticky; set on an inaccessible read or write; cleared by the next accepted start.
err_addr  out  ADDR_W  address of the faulting access.
bus_req  out  1  bus request to the top-level arbiter.
bus_gnt  in  1  bus grant from the arbiter.
rd  out  1  bus read strobe.
wr  out  1  bus write strobe.
addr  out  ADDR_W  bus address.
wdata  out  32  bus write data.
rdata  in  32  bus read data; combinational, valid in the same cycle as rd.
r_accessible  in  1  responder read-decode hit, same cycle as rd.
w_accessible  in  1  responder write-decode hit, registered; valid in the cycle after wr.
irq  out  1  interrupt, only active with the optional feature (see below).

Behaviour:
- Reset values: state IDLE; busy=0, done=0, err=0, err_addr=0, bus_req=0, rd=0, wr=0, addr=0, wdata=0, irq=0; internal src, dst, cnt and data buffer all 0.
- States: IDLE, RD, WR, WCHK, DONE, ERR.
- IDLE:
  - On start, capture the cfg_* values and clear err.
  - If cfg_cnt==0, go to DONE; otherwise go to RD.
- RD:
  - bus_req=1.
  - When bus_gnt=1: rd=1 and addr=src, both combinational.
  - At posedge with gnt:
    - If r_accessible=1, latch rdata into the buffer and go to WR.
    - Otherwise set err_addr=src and go to ERR.
- WR:
  - bus_req=1.
  - When bus_gnt=1: wr=1, addr=dst, wdata=buffer.
  - At posedge with gnt, go to WCHK.
- WCHK:
  - bus_req=1; rd=0 and wr=0.
  - If w_accessible=0: set err_addr=dst and go to ERR.
  - Otherwise:
    - cnt decrements by 1.
    - src advances by 4 if cfg_src_inc; dst advances by 4 if cfg_dst_inc.
    - Address arithmetic is modulo 2^ADDR_W, so it wraps silently.
    - If the new cnt is 0, go to DONE; otherwise go to RD.
- DONE: done=1 for one cycle, then IDLE.
- ERR: err=1 (sticky), then IDLE. Remaining words are abandoned.
- Grant loss: if bus_gnt is low in RD or WR, rd and wr are 0 and the state holds. The transaction is retried when gnt returns and no data is lost.
- Strobes: rd and wr are never both high. Neither is ever high without bus_gnt.
- Throughput: 3 cycles per word with continuous grant. Latency from start to done for N words is 3N+2 cycles.
- Simultaneous events: start while busy is ignored. A done pulse and a new start in the same cycle (start seen in IDLE the next cycle) are legal.
- Reset mid-transfer: an immediate return to the reset values; no partial write is completed.
- Idle bus outputs: addr and wdata hold their last values while rd=0 and wr=0.

Optional Feature:
- BUS_DMA_IRQ_EN defined:
  - Adds input irq_clr (1 bit).
  - irq is set on entry to DONE or ERR, and held until irq_clr=1.
  - If irq_clr and a set event occur in the same cycle, the set wins.
- BUS_DMA_IRQ_EN undefined: irq is tied to 0 and there is no irq_clr port.

Decomposition:
- Shared package bus_dma_pkg holds:
  - the state enum (IDLE, RD, WR, WCHK, DONE, ERR);
  - WORD_STRIDE=4;
  - the bus address constants used by the benches: TH 0x40000000, TL 0x40000004, TCON 0x40000008, LED 0x40000010, SWITCH 0x40000014, DIGI 0x40000018.
- No sub-module; the address and count logic is small enough to inline.

Test Plan:
- Block copy: src=0x100, dst=0x200, cnt=4, both inc, 4-word memory model with continuous gnt -> four rd/wr pairs at 0x100..0x10C and 0x200..0x20C; done pulses at cycle 14 after start; err=0.
- Fixed-address copy to peripheral: switch=0xA5, src=0x40000014, dst=0x40000010, cnt=1, inc=0 -> led reads back 0xA5; done pulses.
- Read error: src=0x40000020 (unmapped) -> r_accessible=0 -> err=1, err_addr=0x40000020, no wr issued, busy drops.
- Write error with stall: dst=0x40000014 (read-only), gnt held low 5 cycles in RD -> rd stays 0 while stalled; then WCHK sees w_accessible=0 -> err=1, err_addr=0x40000014.
- Edge cases: cnt=0 -> done 2 cycles after start with no bus activity. start while busy -> ignored. Reset asserted during WR -> all outputs at their reset values immediately.
- With BUS_DMA_IRQ_EN: irq rises after done and holds until irq_clr; irq_clr coinciding with the ERR entry leaves irq=1.

Source files
------------

// File: rtl/bus_dma_pkg.sv
// bus_dma_pkg: shared types and constants for the bus DMA master and its benches.
// Holds the controller state encoding, the per-word address stride and the
// peripheral register map of the memory-mapped bus.
package bus_dma_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WR   = 3'd2,
      WCHK = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam int WORD_STRIDE = 4;

   localparam logic [31:0] TH     = 32'h4000_0000;
   localparam logic [31:0] TL     = 32'h4000_0004;
   localparam logic [31:0] TCON   = 32'h4000_0008;
   localparam logic [31:0] LED    = 32'h4000_0010;
   localparam logic [31:0] SWITCH = 32'h4000_0014;
   localparam logic [31:0] DIGI   = 32'h4000_0018;

endpackage

// File: rtl/bus_dma_master_if.sv
// bus_dma_master_if: memory-mapped peripheral bus plus the req/gnt pair used by
// the top-level arbiter. The master modport is the DMA side, the slave modport
// is the arbiter/responder side.
interface bus_dma_master_if #(
   parameter int ADDR_W = 32
);

   logic              bus_req;
   logic              bus_gnt;
   logic              rd;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              r_accessible;
   logic              w_accessible;

   modport master (
      output bus_req,
      output rd,
      output wr,
      output addr,
      output wdata,
      input  bus_gnt,
      input  rdata,
      input  r_accessible,
      input  w_accessible
   );

   modport slave (
      input  bus_req,
      input  rd,
      input  wr,
      input  addr,
      input  wdata,
      output bus_gnt,
      output rdata,
      output r_accessible,
      output w_accessible
   );

endinterface

// File: rtl/bus_dma_master.sv
// bus_dma_master: copies cfg_cnt 32-bit words from cfg_src to cfg_dst, one
// read-then-write pair per word, while holding bus_req towards the arbiter.
// A word costs three cycles (RD, WR, WCHK) with continuous grant. The write
// decode answer arrives one cycle after wr, which is why WCHK exists.
// Optional feature: define BUS_DMA_IRQ_EN to add irq_clr and a sticky irq that
// is set on entry to DONE or ERR; otherwise irq is tied low.
module bus_dma_master
   import bus_dma_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] cfg_src,
   input  logic [ADDR_W-1:0] cfg_dst,
   input  logic [CNT_W-1:0]  cfg_cnt,
   input  logic              cfg_src_inc,
   input  logic              cfg_dst_inc,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] err_addr,
   bus_dma_master_if.master  bus,
`ifdef BUS_DMA_IRQ_EN
   input  logic              irq_clr,
`endif
   output logic              irq
);

   localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_STRIDE);

   state_t            state;
   state_t            next_state;

   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [CNT_W-1:0]  cnt;
   logic              src_inc;
   logic              dst_inc;
   logic [31:0]       data_buf;

   logic [ADDR_W-1:0] addr_hold;
   logic [31:0]       wdata_hold;
   logic              done_q;
   logic              err_q;
   logic [ADDR_W-1:0] err_addr_q;

   logic              req_c;
   logic              rd_c;
   logic              wr_c;
   logic [ADDR_W-1:0] addr_c;
   logic [31:0]       wdata_c;

   // State register; reset drops any transfer in flight immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: RD/WR only advance on grant, WCHK decides on the
   // registered write-decode answer and on the remaining word count
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = (cfg_cnt == '0) ? DONE : RD;
            end
         end
         RD: begin
            if (bus.bus_gnt) begin
               next_state = bus.r_accessible ? WR : ERR;
            end
         end
         WR: begin
            if (bus.bus_gnt) begin
               next_state = WCHK;
            end
         end
         WCHK: begin
            if (!bus.w_accessible) begin
               next_state = ERR;
            end else if (cnt == CNT_W'(1)) begin
               next_state = DONE;
            end else begin
               next_state = RD;
            end
         end
         DONE:    next_state = IDLE;
         ERR:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Bus outputs: strobes only with grant, addr/wdata hold their last driven
   // values whenever no strobe is active
   always_comb begin
      req_c   = 1'b0;
      rd_c    = 1'b0;
      wr_c    = 1'b0;
      addr_c  = addr_hold;
      wdata_c = wdata_hold;
      case (state)
         RD: begin
            req_c = 1'b1;
            if (bus.bus_gnt) begin
               rd_c   = 1'b1;
               addr_c = src;
            end
         end
         WR: begin
            req_c = 1'b1;
            if (bus.bus_gnt) begin
               wr_c    = 1'b1;
               addr_c  = dst;
               wdata_c = data_buf;
            end
         end
         WCHK: begin
            req_c = 1'b1;
         end
         default: begin
            req_c = 1'b0;
         end
      endcase
   end

   // Datapath: configuration capture, read buffer, address/count stepping,
   // error capture and the registered done pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         src        <= '0;
         dst        <= '0;
         cnt        <= '0;
         src_inc    <= 1'b0;
         dst_inc    <= 1'b0;
         data_buf   <= '0;
         addr_hold  <= '0;
         wdata_hold <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         if (rd_c || wr_c) begin
            addr_hold <= addr_c;
         end
         if (wr_c) begin
            wdata_hold <= wdata_c;
         end
         done_q <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  src     <= cfg_src;
                  dst     <= cfg_dst;
                  cnt     <= cfg_cnt;
                  src_inc <= cfg_src_inc;
                  dst_inc <= cfg_dst_inc;
                  err_q   <= 1'b0;
               end
            end
            RD: begin
               if (bus.bus_gnt) begin
                  if (bus.r_accessible) begin
                     data_buf <= bus.rdata;
                  end else begin
                     err_addr_q <= src;
                     err_q      <= 1'b1;
                  end
               end
            end
            WCHK: begin
               if (!bus.w_accessible) begin
                  err_addr_q <= dst;
                  err_q      <= 1'b1;
               end else begin
                  cnt <= cnt - CNT_W'(1);
                  if (src_inc) begin
                     src <= src + STRIDE;
                  end
                  if (dst_inc) begin
                     dst <= dst + STRIDE;
                  end
               end
            end
            default: begin
               cnt <= cnt;
            end
         endcase
      end
   end

   assign bus.bus_req = req_c;
   assign bus.rd      = rd_c;
   assign bus.wr      = wr_c;
   assign bus.addr    = addr_c;
   assign bus.wdata   = wdata_c;

   assign busy     = (state != IDLE);
   assign done     = done_q;
   assign err      = err_q;
   assign err_addr = err_addr_q;

`ifdef BUS_DMA_IRQ_EN
   logic irq_q;
   logic irq_set;

   assign irq_set = (next_state != state) && ((next_state == DONE) || (next_state == ERR));

   // Interrupt latches on entry to DONE or ERR; a coincident clear loses
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else if (irq_set) begin
         irq_q <= 1'b1;
      end else if (irq_clr) begin
         irq_q <= 1'b0;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule
